// File: rtl/mine_placer.sv
// Pseudo-random mine placement for the 5x5 board: LFSR draws with a deterministic
// fill fallback, an optional protected first-click cell, and a held result.
module mine_placer #(
  parameter int         NUM_CELLS = 25,
  parameter logic [7:0] SEED      = 8'hA5,
  parameter logic [7:0] MAX_TRIES = 8'd200
) (
  input  logic                 clka,
  input  logic                 restart,
  input  logic                 start,
  input  logic                 seed_load,
  input  logic [7:0]           seed,
  input  logic [4:0]           num_mines,
  input  logic                 safe_en,
  input  logic [4:0]           safe_cell,
  output logic [NUM_CELLS-1:0] mines,
  output logic                 place_done,
  output logic                 busy
);

  typedef enum logic [1:0] {S_IDLE, S_DRAW, S_FILL, S_DONE} state_t;

  state_t               state_q;
  logic [7:0]           lfsr_q;
  logic [7:0]           lfsr_d;
  logic [NUM_CELLS-1:0] mines_q;
  logic                 place_done_q;
  logic [4:0]           count_q;
  logic [4:0]           target_q;
  logic [7:0]           tries_q;
  logic [4:0]           idx_q;
  logic                 safe_en_q;
  logic [4:0]           safe_cell_q;

  logic                 idle_like;
  logic                 accept;
  logic [4:0]           limit;
  logic [4:0]           new_target;
  logic [4:0]           cand;
  logic [31:0]          mines_pad;
  logic [31:0]          cand_oh;
  logic [31:0]          idx_oh;
  logic                 cand_ok;
  logic                 fill_ok;

  always_comb begin
    idle_like  = (state_q == S_IDLE) || (state_q == S_DONE);
    accept     = start && idle_like;
    limit      = safe_en ? 5'd24 : 5'd25;
    new_target = (num_mines > limit) ? limit : num_mines;
    // A zero seed would lock the LFSR, so it is replaced by 1.
    if (seed_load && idle_like) begin
      lfsr_d = (seed == 8'h00) ? 8'h01 : seed;
    end else begin
      lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end
    cand      = lfsr_q[4:0];
    mines_pad = {{(32-NUM_CELLS){1'b0}}, mines_q};
    cand_oh   = 32'd1 << cand;
    idx_oh    = 32'd1 << idx_q;
    cand_ok   = (cand < 5'd25) && !mines_pad[cand] &&
                !(safe_en_q && (cand == safe_cell_q));
    fill_ok   = !mines_pad[idx_q] && !(safe_en_q && (idx_q == safe_cell_q));
  end

  always_ff @(posedge clka) begin
    if (restart) begin
      state_q      <= S_IDLE;
      lfsr_q       <= SEED;
      mines_q      <= '0;
      place_done_q <= 1'b0;
      count_q      <= '0;
      target_q     <= '0;
      tries_q      <= '0;
      idx_q        <= '0;
      safe_en_q    <= 1'b0;
      safe_cell_q  <= '0;
    end else begin
      lfsr_q <= lfsr_d;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (accept) begin
            mines_q      <= '0;
            place_done_q <= 1'b0;
            count_q      <= '0;
            tries_q      <= '0;
            idx_q        <= '0;
            target_q     <= new_target;
            safe_en_q    <= safe_en;
            safe_cell_q  <= safe_cell;
            state_q      <= (new_target == 5'd0) ? S_DONE : S_DRAW;
          end else if (state_q == S_DONE) begin
            // Done is flagged one edge after the final bitmap settles.
            place_done_q <= 1'b1;
          end
        end
        S_DRAW: begin
          tries_q <= tries_q + 8'd1;
          if (cand_ok) begin
            mines_q <= mines_q | cand_oh[NUM_CELLS-1:0];
            count_q <= count_q + 5'd1;
          end
          if (cand_ok && ((count_q + 5'd1) == target_q)) begin
            state_q <= S_DONE;
          end else if ((tries_q + 8'd1) == MAX_TRIES) begin
            state_q <= S_FILL;
          end
        end
        S_FILL: begin
          // Target never exceeds the free cell count, so this ends by cell 24.
          idx_q <= idx_q + 5'd1;
          if (fill_ok) begin
            mines_q <= mines_q | idx_oh[NUM_CELLS-1:0];
            count_q <= count_q + 5'd1;
            if ((count_q + 5'd1) == target_q) begin
              state_q <= S_DONE;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mines      = mines_q;
  assign place_done = place_done_q;
  assign busy       = (state_q == S_DRAW) || (state_q == S_FILL);

endmodule
